clock_enable_gen: RTL and testbench
===================================

// Module: clock_enable_gen
// PURPOSE
//  Multi-channel fractional clock-enable generator; successor to the fixed single-ratio PLL clock block.
//  Runs entirely on one system clock and emits CHANNELS one-cycle enable strobes (ce) and square
//  phase outputs (sq), each at fclk*inc/2^ACC_W, without adding clock domains or BUFGs.
//  Includes a startup hold-off and runtime, glitch-free ratio reprogramming. Feeds CPU/video/audio cores.
// PARAMETERS
//  CHANNELS   4          number of independent enable channels (1..8)
//  ACC_W      24         phase accumulator width; frequency resolution fclk/2^ACC_W
//  STARTUP    1024       cycles after reset before ready rises and channels run (>=1)
//  INC_RESET  {CHANNELS{24'd2348810}}  per-channel reset increment, ch0 in LSBs (7.00 MHz @ 50 MHz)
// PORTS
//  clock      in   1                  system clock, all logic rising-edge
//  reset      in   1                  synchronous, active-high
//  inc_in     in   ACC_W              new increment value
//  inc_sel    in   $clog2(CHANNELS)   channel addressed by inc_wr (min width 1)
//  inc_wr     in   1                  latch inc_in into shadow of channel inc_sel
//  sync       in   1                  realign: clear all accumulators together
//  ready      out  1                  startup hold-off complete
//  ce         out  CHANNELS           one-cycle enable strobe per channel, registered
//  sq         out  CHANNELS           accumulator MSB per channel (~50% duty), registered
// BEHAVIOUR
//  Reset: ready=0, ce=0, sq=0, all acc=0, active inc=INC_RESET slice, shadows=INC_RESET, pending=0.
//  Startup: counter counts 0..STARTUP-1 after reset; ready rises on the cycle count hits STARTUP-1,
//   stays 1 until next reset. While ready=0: acc held 0, ce=0, sq=0; inc_wr still accepted.
//  Run (ready=1): per channel sum = {1'b0,acc} + {1'b0,inc_act} (ACC_W+1 bits); acc <= sum[ACC_W-1:0];
//   ce[i] <= sum[ACC_W] (carry); sq[i] <= sum[ACC_W-1]. Latency: ce high in cycle after the wrapping add.
//  ce is never high two consecutive cycles unless inc_act >= 2^(ACC_W-1); inc_act=0 -> ce never fires.
//  Average ce rate exactly inc_act/2^ACC_W per cycle; no drift (modular, no rounding beyond inc).
//  First ce after ready/sync: cycle ceil(2^ACC_W/inc_act) counting the first add as cycle 1.
//  Reprogram: inc_wr writes shadow[inc_sel], sets pending[inc_sel]. Shadow->inc_act on that
//   channel's next carry cycle (ratio change glitch-free at strobe boundary), clears pending.
//   If inc_act==0 or ready==0, transfer occurs on the next cycle (no carry would ever come).
//   inc_wr on same channel while pending: shadow overwritten, last write wins.
//   inc_wr and carry same cycle, same channel: old shadow transfers, new write stays pending.
//   inc_sel >= CHANNELS: write ignored.
//  Sync (ready=1): next cycle all acc=0, ce=0, sq=0; every pending shadow transfers immediately.
//   sync + inc_wr same cycle: the new inc_in value is the one transferred. sync while ready=0: no effect.
//  Reset mid-operation returns to reset state in one cycle, including ready=0 and new STARTUP wait.
// STRUCTURE
//  Package clock_pkg: ACC_W default, function inc_for(f_clk_hz,f_out_hz)=round(f_out*2^ACC_W/f_clk),
//   STARTUP default, channel-index width helper.
//  Sub-module clock_ce_channel: one accumulator + shadow/pending + ce/sq regs; ports clock, reset,
//   run, sync, wr, inc_in, inc_init, ce, sq. Top: startup counter, write decode, generate loop.
// TESTING
//  Reset then idle, STARTUP=16 -> ready rises 16 cycles after reset release; ce/sq 0 throughout.
//  ACC_W=24, inc=2348810, 50000 cycles -> ch0 ce count 7000 +/-1; no back-to-back ce.
//  inc=2^23 -> ce every 2nd cycle exactly; inc=2^24-1 -> ce on all but one cycle in 2^24; inc=0 -> none.
//  inc_wr ch1 2^22 mid-period while inc_act=2^20 -> rate change exactly at next ch1 ce, not before.
//  Run channels at 2^22 and 2^21, pulse sync with pending write -> all acc 0, ce same cycle; new inc active.
//  Assert reset at cycle 100 of run -> outputs 0 next cycle, ready low, full STARTUP wait repeats.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared defaults and helpers for the clock-enable generator
package clock_pkg;

  localparam int ACC_W_DEFAULT   = 24;
  localparam int STARTUP_DEFAULT = 1024;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Rounded increment giving f_out_hz strobes from an f_clk_hz clock.
  function automatic longint inc_for(input longint f_clk_hz, input longint f_out_hz,
                                     input int acc_w);
    return ((f_out_hz << acc_w) + (f_clk_hz / 2)) / f_clk_hz;
  endfunction

endpackage

// File: rtl/clock_ce_channel.sv
// rtl/clock_ce_channel.sv - one phase accumulator with shadowed increment and ce/sq outputs
module clock_ce_channel
  import clock_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             sync,
  input  logic             wr,
  input  logic [ACC_W-1:0] inc_in,
  input  logic [ACC_W-1:0] inc_init,
  output logic             ce,
  output logic             sq
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_act;
  logic [ACC_W-1:0] shadow;
  logic             pending;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             realign;
  logic             take;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, inc_act};
    carry   = sum[ACC_W];
    realign = run && sync;
    // A stopped or zero-rate channel never carries, so its shadow moves over at once.
    take    = pending && (!run || carry || (inc_act == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      inc_act <= inc_init;
      shadow  <= inc_init;
      pending <= 1'b0;
      ce      <= 1'b0;
      sq      <= 1'b0;
    end else begin
      if (run && !sync) begin
        acc <= sum[ACC_W-1:0];
        ce  <= carry;
        sq  <= sum[ACC_W-1];
      end else begin
        acc <= '0;
        ce  <= 1'b0;
        sq  <= 1'b0;
      end

      if (realign) begin
        if (wr) begin
          inc_act <= inc_in;
        end else if (pending) begin
          inc_act <= shadow;
        end
        pending <= 1'b0;
      end else begin
        if (take) begin
          inc_act <= shadow;
        end
        if (wr) begin
          pending <= 1'b1;
        end else if (take) begin
          pending <= 1'b0;
        end
      end

      if (wr) begin
        shadow <= inc_in;
      end
    end
  end

endmodule

// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - multi-channel fractional clock-enable generator with startup hold-off
module clock_enable_gen
  import clock_pkg::*;
#(
  parameter int                          CHANNELS  = 4,
  parameter int                          ACC_W     = ACC_W_DEFAULT,
  parameter int                          STARTUP   = STARTUP_DEFAULT,
  parameter logic [CHANNELS*ACC_W-1:0]   INC_RESET =
    {CHANNELS{ACC_W'(inc_for(64'd50_000_000, 64'd7_000_000, ACC_W))}}
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [ACC_W-1:0]                   inc_in,
  input  logic [idx_width(CHANNELS)-1:0]     inc_sel,
  input  logic                               inc_wr,
  input  logic                               sync,
  output logic                               ready,
  output logic [CHANNELS-1:0]                ce,
  output logic [CHANNELS-1:0]                sq
);

  localparam int SEL_W = idx_width(CHANNELS);
  localparam int CNT_W = idx_width(STARTUP);

  logic [CNT_W-1:0] count;

  // Counter parks at STARTUP-1 once ready is set; only reset restarts the hold-off.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      ready <= 1'b0;
    end else if (!ready) begin
      if (count == CNT_W'(STARTUP - 1)) begin
        ready <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_ch;

    // Out-of-range selects match no channel and are dropped here.
    assign wr_ch = inc_wr && (inc_sel == SEL_W'(i));

    clock_ce_channel #(
      .ACC_W(ACC_W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .run     (ready),
      .sync    (sync),
      .wr      (wr_ch),
      .inc_in  (inc_in),
      .inc_init(INC_RESET[i*ACC_W +: ACC_W]),
      .ce      (ce[i]),
      .sq      (sq[i])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb/tb_clock_enable_gen.sv - self-checking bench for clock_enable_gen against a behavioural model
module tb_clock_enable_gen;

  localparam int     CH   = 3;
  localparam int     W    = 24;
  localparam int     ST   = 16;
  localparam longint MOD  = 64'd1 << W;
  localparam longint INC0 = 2348810;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          inc_wr  = 1'b0;
  logic          sync    = 1'b0;
  logic [W-1:0]  inc_in  = '0;
  logic [1:0]    inc_sel = '0;
  logic          ready;
  logic [CH-1:0] ce;
  logic [CH-1:0] sq;

  int checks = 0;
  int errors = 0;

  clock_enable_gen #(
    .CHANNELS(CH),
    .ACC_W   (W),
    .STARTUP (ST)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .inc_in (inc_in),
    .inc_sel(inc_sel),
    .inc_wr (inc_wr),
    .sync   (sync),
    .ready  (ready),
    .ce     (ce),
    .sq     (sq)
  );

  always #5 clock = ~clock;

  // Reference: phase kept as a plain integer modulo 2^W, strobe when it wraps.
  longint        m_acc[CH];
  longint        m_inc[CH];
  longint        m_shadow[CH];
  bit            m_pend[CH];
  bit            m_ready = 1'b0;
  bit            m_valid = 1'b0;
  int            m_since = 0;
  logic [CH-1:0] m_ce = '0;
  logic [CH-1:0] m_sq = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1'b1;
      m_since = 0;
      m_ready = 1'b0;
      m_ce    = '0;
      m_sq    = '0;
      for (int c = 0; c < CH; c++) begin
        m_acc[c]    = 0;
        m_inc[c]    = INC0;
        m_shadow[c] = INC0;
        m_pend[c]   = 1'b0;
      end
    end else begin
      bit running;
      running = m_ready;
      m_since = m_since + 1;
      m_ready = (m_since >= ST);
      for (int c = 0; c < CH; c++) begin
        bit     wr;
        bit     wrapped;
        longint s;
        wr      = inc_wr && (inc_sel == c);
        wrapped = 1'b0;
        if (running && !sync) begin
          s        = m_acc[c] + m_inc[c];
          wrapped  = (s >= MOD);
          m_acc[c] = s % MOD;
          m_ce[c]  = wrapped;
          m_sq[c]  = (m_acc[c] >= MOD / 2);
        end else begin
          m_acc[c] = 0;
          m_ce[c]  = 1'b0;
          m_sq[c]  = 1'b0;
        end
        if (running && sync) begin
          if (wr) m_inc[c] = inc_in;
          else if (m_pend[c]) m_inc[c] = m_shadow[c];
          m_pend[c] = 1'b0;
          if (wr) m_shadow[c] = inc_in;
        end else begin
          if (m_pend[c] && (!running || wrapped || m_inc[c] == 0)) begin
            m_inc[c]  = m_shadow[c];
            m_pend[c] = 1'b0;
          end
          if (wr) begin
            m_shadow[c] = inc_in;
            m_pend[c]   = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      checks++;
      if (ready !== m_ready || ce !== m_ce || sq !== m_sq) begin
        errors++;
        $display("FAIL model t=%0t got ready=%b ce=%b sq=%b want ready=%b ce=%b sq=%b",
                 $time, ready, ce, sq, m_ready, m_ce, m_sq);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_range(input string name, input longint got, input longint lo,
                             input longint hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic write(input int sel, input longint val);
    inc_wr  = 1'b1;
    inc_sel = sel[1:0];
    inc_in  = val[W-1:0];
    @(negedge clock);
    inc_wr  = 1'b0;
  endtask

  // Counts cycles from a just-released reset until ready, then until the first ch0 strobe.
  task automatic startup_and_first_ce(input string tag);
    int n;
    int noisy;
    n     = 0;
    noisy = 0;
    while (!ready && n < 100) begin
      tick(1);
      n++;
      if (ce !== '0 || sq !== '0) noisy++;
    end
    check({tag, "_ready_delay"}, n, ST);
    check({tag, "_quiet_startup"}, noisy, 0);
    n = 0;
    while (ce[0] !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    check({tag, "_first_ce"}, n, 8);
    check({tag, "_first_ce_all"}, ce, 3'b111);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int            cnt;
    int            b2b;
    int            alt;
    logic          prev;
    logic [63:0]   pat;
    logic [63:0]   exp_pat;
    logic [CH-1:0] ce_tab [1:8];
    int            sel;
    int            kind;
    longint        val;

    reset = 1'b1;
    tick(3);
    check("reset_ready", ready, 0);
    check("reset_ce", ce, 0);
    check("reset_sq", sq, 0);
    reset = 1'b0;
    startup_and_first_ce("boot");

    // Long run on ch0 at the 7 MHz ratio while other channels get rewritten.
    cnt  = 0;
    b2b  = 0;
    prev = ce[0];
    for (int i = 0; i < 50000; i++) begin
      if ($urandom_range(0, 63) == 0)
        write($urandom_range(1, 3), longint'($urandom_range(1 << 20, (1 << 24) - 1)));
      else
        tick(1);
      cnt += int'(ce[0]);
      if (ce[0] && prev) b2b++;
      prev = ce[0];
    end
    check_range("rate_7mhz", cnt, 6999, 7001);
    check("rate_7mhz_no_b2b", b2b, 0);

    write(0, 64'd1 << 23);
    tick(20);
    alt  = 0;
    cnt  = 0;
    prev = ce[0];
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ce[0] == prev) alt++;
      cnt += int'(ce[0]);
      prev = ce[0];
    end
    check("half_rate_alternates", alt, 0);
    check("half_rate_count", cnt, 10);

    write(2, 0);
    tick(40);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      cnt += int'(ce[2]);
    end
    check("zero_inc_silent", cnt, 0);
    write(2, (64'd1 << 24) - 1);
    tick(5);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      cnt += int'(ce[2]);
    end
    check_range("max_inc_nearly_always", cnt, 199, 200);

    // Sync with a same-cycle write, then reprogram ch1 mid-period.
    inc_wr  = 1'b1;
    inc_sel = 2'd1;
    inc_in  = W'(1 << 20);
    sync    = 1'b1;
    tick(1);
    inc_wr  = 1'b0;
    sync    = 1'b0;
    check("sync_ce_clear", ce, 0);
    check("sync_sq_clear", sq, 0);
    pat = '0;
    for (int k = 1; k <= 48; k++) begin
      if (k == 21) begin
        inc_wr  = 1'b1;
        inc_sel = 2'd1;
        inc_in  = W'(1 << 22);
      end
      tick(1);
      inc_wr = 1'b0;
      pat[k] = ce[1];
    end
    exp_pat = '0;
    exp_pat[16] = 1'b1;
    exp_pat[32] = 1'b1;
    exp_pat[36] = 1'b1;
    exp_pat[40] = 1'b1;
    exp_pat[44] = 1'b1;
    exp_pat[48] = 1'b1;
    check("reprog_at_strobe", pat, exp_pat);

    write(0, 64'd1 << 22);
    write(1, 64'd1 << 21);
    inc_wr  = 1'b1;
    inc_sel = 2'd2;
    inc_in  = W'(1 << 22);
    sync    = 1'b1;
    tick(1);
    inc_wr  = 1'b0;
    sync    = 1'b0;
    check("sync2_ce_clear", ce, 0);
    ce_tab = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b111};
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check($sformatf("sync_align_k%0d", k), ce, ce_tab[k]);
    end

    // Free random traffic, including writes to the unused select value.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel  = $urandom_range(0, 3);
        kind = $urandom_range(0, 3);
        case (kind)
          0:       val = 0;
          1:       val = 64'd1 << 23;
          2:       val = (64'd1 << 24) - 1;
          default: val = longint'($urandom_range(0, (1 << 24) - 1));
        endcase
        inc_wr  = 1'b1;
        inc_sel = sel[1:0];
        inc_in  = val[W-1:0];
      end
      sync = ($urandom_range(0, 63) == 0);
      tick(1);
      inc_wr = 1'b0;
      sync   = 1'b0;
    end

    tick(100);
    reset = 1'b1;
    tick(1);
    check("midrun_reset_ready", ready, 0);
    check("midrun_reset_ce", ce, 0);
    check("midrun_reset_sq", sq, 0);
    reset = 1'b0;
    startup_and_first_ce("rerun");
    tick(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
